// File: rtl/collision_checker.sv
// ---------------------------------------------------------------------------
// collision_checker
//
// Once per frame, takes a snapshot of the packed obstacle bus and the
// player's lane and jump state. It then walks the snapshot one slot per
// clock and decides whether the player hit an obstacle or collected coins.
// A hit latches a sticky collision. The block then stays in DEAD until a
// restart pulse clears it.
//
// Ports
//   clk_in        system clock
//   rst_in        asynchronous reset, active-low
//   frame_in      one-cycle pulse starting a scan (honoured in IDLE only)
//   restart_in    one-cycle pulse: clear collision/hit_slot, abort, go IDLE
//   obstacles_in  SLOTS packed records {valid, lane[1:0], sprite[1:0], depth[9:0]}
//   player_lane   player lane (0..2)
//   player_jump   player is airborne
//   busy_out      scan in progress
//   done_out      one-cycle pulse; results valid on this cycle
//   collision_out sticky collision flag
//   hit_slot      lowest slot index that caused the collision
//   coins_out     coins collected in the last completed scan
// ---------------------------------------------------------------------------
module collision_checker #(
    parameter int SLOTS    = 10,
    parameter int SLOT_W   = 15,
    parameter int HIT_NEAR = 0,
    parameter int HIT_FAR  = 40
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    frame_in,
    input  logic                    restart_in,
    input  logic [SLOTS*SLOT_W-1:0] obstacles_in,
    input  logic [1:0]              player_lane,
    input  logic                    player_jump,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    collision_out,
    output logic [3:0]              hit_slot,
    output logic [3:0]              coins_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE,
        ST_DEAD
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(SLOTS - 1);
    localparam logic [3:0] COIN_MAX  = 4'd15;

    state_t r_state;
    state_t w_next_state;

    // Frame snapshot and scan accumulators
    logic [SLOTS*SLOT_W-1:0] r_obs;
    logic [1:0]              r_lane;
    logic                    r_jump;
    logic [3:0]              r_idx;
    logic                    r_hit_any;
    logic [3:0]              r_hit_idx;
    logic [3:0]              r_coin_cnt;

    // Registered results
    logic       r_done;
    logic       r_collision;
    logic [3:0] r_hit_slot;
    logic [3:0] r_coins;

    // Decode of the slot currently under the scan index
    logic [SLOT_W-1:0] w_slot;
    logic              w_valid;
    logic [1:0]        w_lane;
    logic [1:0]        w_sprite;
    logic [9:0]        w_depth;
    logic              w_in_window;
    logic              w_hit;
    logic              w_coin;

    always_comb begin
        w_slot   = r_obs[int'(r_idx)*SLOT_W +: SLOT_W];
        w_valid  = w_slot[14];
        w_lane   = w_slot[13:12];
        w_sprite = w_slot[11:10];
        w_depth  = w_slot[9:0];
        // Depth is promoted to a signed int so the window bounds compare
        // cleanly even when HIT_NEAR is zero.
        w_in_window = w_valid && (w_lane == r_lane) &&
                      (int'(w_depth) >= HIT_NEAR) && (int'(w_depth) <= HIT_FAR);
        // A low barrier (sprite 0) is only dangerous while on the ground.
        w_hit  = w_in_window && ((w_sprite == 2'd1) || (w_sprite == 2'd2) ||
                                 ((w_sprite == 2'd0) && !r_jump));
        w_coin = w_in_window && (w_sprite == 2'd3);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        if (restart_in) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (frame_in) w_next_state = ST_SCAN;
                ST_SCAN: if (r_idx == LAST_IDX) w_next_state = ST_DONE;
                ST_DONE: w_next_state = r_hit_any ? ST_DEAD : ST_IDLE;
                ST_DEAD: w_next_state = ST_DEAD;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_out      = (r_state == ST_SCAN);
        done_out      = r_done;
        collision_out = r_collision;
        hit_slot      = r_hit_slot;
        coins_out     = r_coins;
    end

    // ---------------- Datapath: snapshot, accumulators, results ----------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: the snapshot is an ordinary register bank, not a RAM, so it
            // is reset along with everything else and reads 0 out of reset.
            r_obs       <= '0;
            r_lane      <= '0;
            r_jump      <= 1'b0;
            r_idx       <= '0;
            r_hit_any   <= 1'b0;
            r_hit_idx   <= '0;
            r_coin_cnt  <= '0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
            r_hit_slot  <= '0;
            r_coins     <= '0;
        end else begin
            r_done <= 1'b0;
            if (restart_in) begin
                // Aborting needs no extra work: the next accepted frame
                // reinitialises the scan state.
                r_collision <= 1'b0;
                r_hit_slot  <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (frame_in) begin
                            r_obs      <= obstacles_in;
                            r_lane     <= player_lane;
                            r_jump     <= player_jump;
                            r_idx      <= '0;
                            r_hit_any  <= 1'b0;
                            r_hit_idx  <= '0;
                            r_coin_cnt <= '0;
                        end
                    end
                    ST_SCAN: begin
                        // Only the first hit is recorded, giving the lowest index.
                        if (w_hit && !r_hit_any) begin
                            r_hit_any <= 1'b1;
                            r_hit_idx <= r_idx;
                        end
                        if (w_coin && (r_coin_cnt != COIN_MAX)) begin
                            r_coin_cnt <= r_coin_cnt + 4'd1;
                        end
                        // The index parks on the last slot so it never leaves
                        // the snapshot's range.
                        if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        r_done  <= 1'b1;
                        r_coins <= r_coin_cnt;
                        if (r_hit_any) begin
                            r_collision <= 1'b1;
                            r_hit_slot  <= r_hit_idx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// ---------------------------------------------------------------------------
// tb_collision_checker
//
// Directed scenarios followed by randomized frames. Expected results come
// from a slot-by-slot reference model of the hit/coin rules. A small
// scoreboard holds the sticky collision, hit slot, coin count and dead flag.
// ---------------------------------------------------------------------------
module tb_collision_checker;

    localparam int SLOTS    = 10;
    localparam int SLOT_W   = 15;
    localparam int BUS_W    = SLOTS * SLOT_W;
    localparam int HIT_NEAR = 0;
    localparam int HIT_FAR  = 40;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             frame_in;
    logic             restart_in;
    logic [BUS_W-1:0] obstacles_in;
    logic [1:0]       player_lane;
    logic             player_jump;
    logic             busy_out;
    logic             done_out;
    logic             collision_out;
    logic [3:0]       hit_slot;
    logic [3:0]       coins_out;

    int checks = 0;
    int errors = 0;

    // Scoreboard of the expected externally visible state
    bit m_collision;
    int m_hit_slot;
    int m_coins;
    bit m_dead;

    collision_checker #(
        .SLOTS   (SLOTS),
        .SLOT_W  (SLOT_W),
        .HIT_NEAR(HIT_NEAR),
        .HIT_FAR (HIT_FAR)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .frame_in     (frame_in),
        .restart_in   (restart_in),
        .obstacles_in (obstacles_in),
        .player_lane  (player_lane),
        .player_jump  (player_jump),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .collision_out(collision_out),
        .hit_slot     (hit_slot),
        .coins_out    (coins_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; all driving and sampling happen here.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] put(input logic [BUS_W-1:0] obs, input int k,
                                             input logic v, input logic [1:0] l,
                                             input logic [1:0] s, input int d);
        obs[k*SLOT_W +: SLOT_W] = {v, l, s, 10'(d)};
        return obs;
    endfunction

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] b;
        for (int i = 0; i < BUS_W; i++) b[i] = 1'($urandom);
        return b;
    endfunction

    // Reference: apply the hit/coin rules to every slot in index order.
    task automatic model(input logic [BUS_W-1:0] obs, input logic [1:0] lane, input logic jmp,
                         output bit hit, output int slot, output int coins);
        hit = 0; slot = 0; coins = 0;
        for (int k = 0; k < SLOTS; k++) begin
            logic [SLOT_W-1:0] rec;
            int  depth;
            bit  in_win;
            rec    = obs[k*SLOT_W +: SLOT_W];
            depth  = int'(rec[9:0]);
            in_win = rec[14] && (rec[13:12] == lane) && depth >= HIT_NEAR && depth <= HIT_FAR;
            if (in_win && !hit && (rec[11:10] == 2'd1 || rec[11:10] == 2'd2 ||
                                   (rec[11:10] == 2'd0 && !jmp))) begin
                hit  = 1;
                slot = k;
            end
            if (in_win && rec[11:10] == 2'd3 && coins < 15) coins++;
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, ".collision"}, collision_out, m_collision);
        check({tag, ".hit_slot"}, hit_slot, m_hit_slot);
        check({tag, ".coins"}, coins_out, m_coins);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, ".done"}, done_out, 0);
            check({tag, ".busy"}, busy_out, 0);
        end
    endtask

    // Pulse frame_in and follow the whole scan window. An optional second
    // frame pulse lands at edge N+extra_at (0 disables it).
    task automatic run_frame(input string tag, input logic [BUS_W-1:0] obs,
                             input logic [1:0] lane, input logic jmp, input int extra_at);
        bit exp_hit;
        int exp_slot;
        int exp_coins;
        bit accept;
        accept = !m_dead;
        model(obs, lane, jmp, exp_hit, exp_slot, exp_coins);
        obstacles_in = obs;
        player_lane  = lane;
        player_jump  = jmp;
        frame_in     = 1'b1;
        tick();  // edge N
        frame_in = 1'b0;
        // Scramble the inputs; the scan must use the snapshot.
        obstacles_in = rand_bus();
        player_lane  = 2'($urandom_range(0, 3));
        player_jump  = 1'($urandom);
        check({tag, ".busy_start"}, busy_out, accept);
        for (int c = 1; c <= 10; c++) begin
            if (c == extra_at) frame_in = 1'b1;
            tick();  // edge N+c
            frame_in = 1'b0;
            check({tag, ".done_early"}, done_out, 0);
            check({tag, ".busy_scan"}, busy_out, (c <= 9) ? accept : 1'b0);
        end
        tick();  // edge N+11
        if (accept) begin
            m_coins = exp_coins;
            if (exp_hit) begin
                m_collision = 1;
                m_hit_slot  = exp_slot;
                m_dead      = 1;
            end
        end
        check({tag, ".done"}, done_out, accept);
        check_results(tag);
        tick();  // edge N+12
        check({tag, ".done_end"}, done_out, 0);
        check({tag, ".busy_end"}, busy_out, 0);
    endtask

    task automatic do_restart(input string tag);
        restart_in = 1'b1;
        tick();
        restart_in  = 1'b0;
        m_collision = 0;
        m_hit_slot  = 0;
        m_dead      = 0;
        check({tag, ".busy"}, busy_out, 0);
        check_results(tag);
    endtask

    initial begin
        logic [BUS_W-1:0] obs;
        rst_in       = 1'b0;
        frame_in     = 1'b0;
        restart_in   = 1'b0;
        obstacles_in = '0;
        player_lane  = '0;
        player_jump  = 1'b0;
        m_collision  = 0;
        m_hit_slot   = 0;
        m_coins      = 0;
        m_dead       = 0;

        // Reset state
        tick();
        tick();
        check("reset.busy", busy_out, 0);
        check("reset.done", done_out, 0);
        check_results("reset");
        rst_in = 1'b1;
        tick();

        // Lane 2, airborne: low barrier cleared; coins at depth 0 and 40 count, 41 does not
        obs = '0;
        obs = put(obs, 0, 1'b1, 2'd2, 2'd0, 10);
        obs = put(obs, 4, 1'b1, 2'd2, 2'd3, 0);
        obs = put(obs, 7, 1'b1, 2'd2, 2'd3, 40);
        obs = put(obs, 9, 1'b1, 2'd2, 2'd3, 41);
        run_frame("coins_jump", obs, 2'd2, 1'b1, 0);

        // Reset at N+5 of a scan that would hit
        obstacles_in = put('0, 0, 1'b1, 2'd0, 2'd2, 3);
        player_lane  = 2'd0;
        player_jump  = 1'b0;
        frame_in     = 1'b1;
        tick();  // edge N
        frame_in = 1'b0;
        repeat (5) tick();  // edge N+5
        rst_in = 1'b0;
        #1;
        m_collision = 0; m_hit_slot = 0; m_coins = 0; m_dead = 0;
        check("midreset.busy", busy_out, 0);
        check("midreset.done", done_out, 0);
        check_results("midreset");
        tick();
        rst_in = 1'b1;
        idle_cycles(12, "midreset_after");

        // Lane 1 on the ground: tall barrier in slot 3 -> collision at slot 3
        obs = put('0, 3, 1'b1, 2'd1, 2'd1, 20);
        run_frame("tall_hit", obs, 2'd1, 1'b0, 0);
        run_frame("dead_frame", '0, 2'd1, 1'b0, 0);
        do_restart("restart1");
        run_frame("after_restart", '0, 2'd1, 1'b0, 0);

        // Same coin setup on the ground plus trains: lowest hit index is 0
        obs = '0;
        obs = put(obs, 0, 1'b1, 2'd2, 2'd0, 10);
        obs = put(obs, 2, 1'b1, 2'd2, 2'd2, 15);
        obs = put(obs, 4, 1'b1, 2'd2, 2'd3, 0);
        obs = put(obs, 5, 1'b1, 2'd2, 2'd2, 30);
        obs = put(obs, 7, 1'b1, 2'd2, 2'd3, 40);
        obs = put(obs, 9, 1'b1, 2'd2, 2'd3, 41);
        run_frame("low_hit", obs, 2'd2, 1'b0, 0);
        do_restart("restart2");

        // Invalid train ignored; second frame pulse at N+4 dropped
        obs = put('0, 1, 1'b0, 2'd0, 2'd2, 5);
        run_frame("invalid_drop", obs, 2'd0, 1'b0, 4);

        // All slots are in-window coins
        obs = '0;
        for (int k = 0; k < SLOTS; k++) obs = put(obs, k, 1'b1, 2'd0, 2'd3, 4 * k);
        run_frame("all_coins", obs, 2'd0, 1'b1, 0);

        // restart_in wins over frame_in on the same cycle
        restart_in = 1'b1;
        frame_in   = 1'b1;
        tick();
        restart_in = 1'b0;
        frame_in   = 1'b0;
        check("restart_frame.busy", busy_out, 0);
        check_results("restart_frame");
        idle_cycles(12, "restart_frame_after");

        // Randomized frames; biased towards the window and the player's lane
        for (int it = 0; it < 30; it++) begin
            logic [1:0] lane;
            lane = 2'($urandom_range(0, 3));
            obs  = '0;
            for (int k = 0; k < SLOTS; k++) begin
                obs = put(obs, k, 1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 1) != 0) ? lane : 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), int'($urandom_range(0, 60)));
            end
            run_frame("random", obs, lane, 1'($urandom), 0);
            if (m_dead) do_restart("random_restart");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_checker.md
# collision_checker

Consumer of the obstacle generator's obstacle bus and player state. Once per frame it snapshots the packed obstacle list and the player's lane and jump state. It then scans one slot per clock to decide whether the player hit an obstacle or collected coins. Results go to the game-state FSM, which ends the run or adds to the score.

## Interface
Parameters:
- SLOTS, 10, number of obstacle records on the bus
- SLOT_W, 15, bits per record; bus width is SLOTS*SLOT_W = 150
- HIT_NEAR, 0, smallest depth (inclusive) counted as overlapping the player
- HIT_FAR, 40, largest depth (inclusive) counted as overlapping the player

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- frame_in  input  1  one-cycle pulse starting a check
- restart_in  input  1  one-cycle pulse that clears a latched collision
- obstacles_in  input  150  packed records; slot k occupies bits [k*15+14 : k*15]
- player_lane  input  2  player lane, 0..2
- player_jump  input  1  player is airborne
- busy_out  output  1  scan in progress
- done_out  output  1  one-cycle pulse; results are valid on this cycle
- collision_out  output  1  sticky collision flag
- hit_slot  output  4  lowest slot index that caused the collision
- coins_out  output  4  coins collected in the last completed scan

## Operation
- Record format, per slot:
  - bit 14 = valid
  - [13:12] = lane
  - [11:10] = sprite
  - [9:0] = depth (unsigned; 0 is at the player)
- Sprite encoding:
  - 0 = low barrier, jumpable
  - 1 = tall barrier
  - 2 = train
  - 3 = coin
- A slot is "in window" when it is valid, its lane equals the latched lane, and HIT_NEAR <= depth <= HIT_FAR.
- Hit: the slot is in window and either sprite is 1 or 2, or sprite is 0 with the latched jump = 0.
- Coin: the slot is in window and sprite is 3. Jump state is ignored for coins.
- FSM states:
  - IDLE: on frame_in, latch obstacles_in, player_lane and player_jump; clear the scan index, hit accumulator and coin accumulator; go to SCAN.
  - SCAN: evaluate slot[idx] and increment idx. The first hit records idx as the hit slot; later hits leave it unchanged. Each coin increments the coin count, saturating at 15. After slot SLOTS-1, go to DONE.
  - DONE (one cycle): pulse done_out and update coins_out. If any hit occurred, set collision_out, update hit_slot and go to DEAD; otherwise go to IDLE.
  - DEAD: ignore frame_in.
- restart_in, in any state: clear collision_out and hit_slot, abort any scan, go to IDLE. restart_in has priority over frame_in on the same cycle.
- frame_in in SCAN, DONE or DEAD is dropped. No queuing.
- A player_lane value of 3 never matches a record lane of 0..2, but a record with lane 3 does match it. No special-casing.
- Changes to the inputs after the latch do not affect the scan in progress.

## Timing
- Reset (rst_in low, at any time, including mid-scan): FSM goes to IDLE immediately. All of busy_out, done_out, collision_out, hit_slot and coins_out read 0. Internal snapshot and counters read 0.
- frame_in is high at edge N (sampled in IDLE). From edge N the block is in SCAN with busy_out = 1.
- Slot k is evaluated on edge N+1+k, for k = 0..9.
- Edge N+11: DONE. done_out = 1 for exactly one cycle; busy_out = 0 from this cycle.
- Edge N+12: back in IDLE (or DEAD). A new frame_in is accepted here.
- Minimum frame period: 12 cycles.
- collision_out, hit_slot and coins_out change only at the DONE edge, restart or reset. coins_out holds its value between scans.
- busy_out is 1 in SCAN only.

## Test plan
- Run reset mid-scan: assert frame_in, then pull rst_in low at N+5. All outputs must be 0 immediately, and the block must be IDLE with no done_out afterwards.
- Lane 1, jump 0; slot 3 is a tall barrier in lane 1 at depth 20. Expect done_out at N+11, collision_out = 1 and hit_slot = 3. A later frame_in must give no done_out. After restart_in, collision_out = 0 and a new frame_in is accepted.
- Lane 2, jump 1; slot 0 is a low barrier in lane 2 at depth 10, and slots 4, 7 and 9 are coins in lane 2 at depths 0, 40 and 41. Expect collision_out = 0 and coins_out = 2.
- Same setup with jump 0: collision_out = 1 and hit_slot = 0. Also set slots 2 and 5 as trains in the same lane; hit_slot must still be 0 (lowest index).
- Slot 1 is a train in lane 0 at depth 5 with valid = 0. Expect no collision. Then a second frame_in pulse at N+4 is dropped, giving exactly one done_out at N+11.
- All 10 slots are in-window coins. Expect coins_out = 10. Also assert restart_in and frame_in on the same cycle: the block stays IDLE and produces no done_out.
